// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the EX-stage ALU.
// Holds the decoded instruction for one cycle and drives Ctl, Shamt,
// DataA and DataB straight into the ALU. DataA and DataB are forwarded
// from MEM or WB, with MEM taking priority. DataB can instead be the
// immediate when ALUSrc is set.
// Stall goes high for a load-use hazard, and the stage then loads a bubble.
// Flush also loads a bubble and overrides Stall.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   ID_*                     decoded instruction from ID
//   Flush                    kill the ID instruction (taken branch/jump)
//   MEM_*, WB_*              forwarding sources
//   Stall                    hold PC and IF/ID (combinational)
//   EX_*                     registered instruction and forwarded operands
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ID_Valid,
  input  logic [REG_W-1:0]  ID_Rs,
  input  logic [REG_W-1:0]  ID_Rt,
  input  logic [REG_W-1:0]  ID_Rd,
  input  logic [DATA_W-1:0] ID_RsData,
  input  logic [DATA_W-1:0] ID_RtData,
  input  logic [DATA_W-1:0] ID_Imm,
  input  logic              ID_ALUSrc,
  input  logic [2:0]        ID_Ctl,
  input  logic [4:0]        ID_Shamt,
  input  logic              ID_RegWrite,
  input  logic              ID_MemRead,
  input  logic              ID_MemWrite,
  input  logic              Flush,
  input  logic              MEM_RegWrite,
  input  logic [REG_W-1:0]  MEM_Rd,
  input  logic [DATA_W-1:0] MEM_Data,
  input  logic              WB_RegWrite,
  input  logic [REG_W-1:0]  WB_Rd,
  input  logic [DATA_W-1:0] WB_Data,
  output logic              Stall,
  output logic              EX_Valid,
  output logic [2:0]        EX_Ctl,
  output logic [4:0]        EX_Shamt,
  output logic [DATA_W-1:0] EX_DataA,
  output logic [DATA_W-1:0] EX_DataB,
  output logic [DATA_W-1:0] EX_StoreData,
  output logic [REG_W-1:0]  EX_Rd,
  output logic              EX_RegWrite,
  output logic              EX_MemRead,
  output logic              EX_MemWrite
);

  logic              valid_q;
  logic [REG_W-1:0]  rs_q;
  logic [REG_W-1:0]  rt_q;
  logic [REG_W-1:0]  rd_q;
  logic [DATA_W-1:0] rsdata_q;
  logic [DATA_W-1:0] rtdata_q;
  logic [DATA_W-1:0] imm_q;
  logic              alusrc_q;
  logic [2:0]        ctl_q;
  logic [4:0]        shamt_q;
  logic              regwrite_q;
  logic              memread_q;
  logic              memwrite_q;

  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;

  // Rt is compared even for instructions that do not read it.
  // A stall clears EX_MemRead, so it ends after one cycle.
  always_comb begin
    Stall = ~Flush & ID_Valid & valid_q & memread_q & (rd_q != '0) &
            ((rd_q == ID_Rs) | (rd_q == ID_Rt));
  end

  always_ff @(posedge clk) begin
    if (rst || Flush || Stall) begin
      valid_q    <= 1'b0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      rsdata_q   <= '0;
      rtdata_q   <= '0;
      imm_q      <= '0;
      alusrc_q   <= 1'b0;
      ctl_q      <= '0;
      shamt_q    <= '0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
    end else begin
      valid_q    <= ID_Valid;
      rs_q       <= ID_Rs;
      rt_q       <= ID_Rt;
      rd_q       <= ID_Rd;
      rsdata_q   <= ID_RsData;
      rtdata_q   <= ID_RtData;
      imm_q      <= ID_Imm;
      alusrc_q   <= ID_ALUSrc;
      ctl_q      <= ID_Ctl;
      shamt_q    <= ID_Shamt;
      regwrite_q <= ID_RegWrite;
      memread_q  <= ID_MemRead;
      memwrite_q <= ID_MemWrite;
    end
  end

  // Register 0 is never forwarded.
  always_comb begin
    fwd_a = rsdata_q;
    if (MEM_RegWrite && (MEM_Rd != '0) && (MEM_Rd == rs_q))
      fwd_a = MEM_Data;
    else if (WB_RegWrite && (WB_Rd != '0) && (WB_Rd == rs_q))
      fwd_a = WB_Data;

    fwd_b = rtdata_q;
    if (MEM_RegWrite && (MEM_Rd != '0) && (MEM_Rd == rt_q))
      fwd_b = MEM_Data;
    else if (WB_RegWrite && (WB_Rd != '0) && (WB_Rd == rt_q))
      fwd_b = WB_Data;
  end

  always_comb begin
    EX_Valid     = valid_q;
    EX_Ctl       = ctl_q;
    EX_Shamt     = shamt_q;
    EX_DataA     = fwd_a;
    EX_DataB     = alusrc_q ? imm_q : fwd_b;
    EX_StoreData = fwd_b;
    EX_Rd        = rd_q;
    EX_RegWrite  = regwrite_q;
    EX_MemRead   = memread_q;
    EX_MemWrite  = memwrite_q;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ID_Valid = 1'b0;
  logic [4:0]  ID_Rs = '0, ID_Rt = '0, ID_Rd = '0;
  logic [31:0] ID_RsData = '0, ID_RtData = '0, ID_Imm = '0;
  logic        ID_ALUSrc = 1'b0;
  logic [2:0]  ID_Ctl = '0;
  logic [4:0]  ID_Shamt = '0;
  logic        ID_RegWrite = 1'b0, ID_MemRead = 1'b0, ID_MemWrite = 1'b0;
  logic        Flush = 1'b0;
  logic        MEM_RegWrite = 1'b0;
  logic [4:0]  MEM_Rd = '0;
  logic [31:0] MEM_Data = '0;
  logic        WB_RegWrite = 1'b0;
  logic [4:0]  WB_Rd = '0;
  logic [31:0] WB_Data = '0;
  logic        Stall;
  logic        EX_Valid;
  logic [2:0]  EX_Ctl;
  logic [4:0]  EX_Shamt;
  logic [31:0] EX_DataA, EX_DataB, EX_StoreData;
  logic [4:0]  EX_Rd;
  logic        EX_RegWrite, EX_MemRead, EX_MemWrite;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .REG_W(5)) dut (
    .clk(clk), .rst(rst),
    .ID_Valid(ID_Valid), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd),
    .ID_RsData(ID_RsData), .ID_RtData(ID_RtData), .ID_Imm(ID_Imm),
    .ID_ALUSrc(ID_ALUSrc), .ID_Ctl(ID_Ctl), .ID_Shamt(ID_Shamt),
    .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
    .Flush(Flush),
    .MEM_RegWrite(MEM_RegWrite), .MEM_Rd(MEM_Rd), .MEM_Data(MEM_Data),
    .WB_RegWrite(WB_RegWrite), .WB_Rd(WB_Rd), .WB_Data(WB_Data),
    .Stall(Stall), .EX_Valid(EX_Valid), .EX_Ctl(EX_Ctl), .EX_Shamt(EX_Shamt),
    .EX_DataA(EX_DataA), .EX_DataB(EX_DataB), .EX_StoreData(EX_StoreData),
    .EX_Rd(EX_Rd), .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead),
    .EX_MemWrite(EX_MemWrite)
  );

  // Reference: the instruction currently sitting in EX, as an abstract record.
  typedef struct packed {
    logic        v;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rsd, rtd, imm;
    logic        alusrc;
    logic [2:0]  ctl;
    logic [4:0]  sh;
    logic        rw, mr, mw;
  } ex_t;

  localparam int OW = 1 + 3 + 5 + 32 * 3 + 5 + 3;

  ex_t m = '0;
  int  tests = 0;
  int  fails = 0;

  logic [OW-1:0] dut_out;
  assign dut_out = {EX_Valid, EX_Ctl, EX_Shamt, EX_DataA, EX_DataB, EX_StoreData,
                    EX_Rd, EX_RegWrite, EX_MemRead, EX_MemWrite};

  // Value an operand should take: newest producer wins, r0 is always the file value.
  function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] d);
    if (r == 0) return d;
    if (MEM_RegWrite && MEM_Rd == r) return MEM_Data;
    if (WB_RegWrite && WB_Rd == r) return WB_Data;
    return d;
  endfunction

  function automatic logic [OW-1:0] exp_out();
    logic [31:0] a = operand(m.rs, m.rsd);
    logic [31:0] b = operand(m.rt, m.rtd);
    return {m.v, m.ctl, m.sh, a, (m.alusrc ? m.imm : b), b, m.rd, m.rw, m.mr, m.mw};
  endfunction

  // A valid load in EX whose (nonzero) target is read by a valid ID instruction.
  function automatic logic exp_stall();
    if (Flush || !ID_Valid || !m.v || !m.mr || m.rd == 0) return 1'b0;
    return (m.rd == ID_Rs) || (m.rd == ID_Rt);
  endfunction

  task automatic tick();
    ex_t n;
    if (rst || Flush || exp_stall())
      n = '0;
    else
      n = {ID_Valid, ID_Rs, ID_Rt, ID_Rd, ID_RsData, ID_RtData, ID_Imm, ID_ALUSrc,
           ID_Ctl, ID_Shamt, ID_RegWrite, ID_MemRead, ID_MemWrite};
    @(posedge clk);
    m = n;
    #1;
  endtask

  task automatic rand_id();
    ID_Valid = 1'b1;
    ID_Rs = 5'($urandom_range(0, 7));
    ID_Rt = 5'($urandom_range(0, 7));
    ID_Rd = 5'($urandom_range(0, 7));
    ID_RsData = $urandom; ID_RtData = $urandom; ID_Imm = $urandom;
    ID_ALUSrc = 1'($urandom); ID_Ctl = 3'($urandom); ID_Shamt = 5'($urandom);
    ID_RegWrite = 1'($urandom); ID_MemRead = 1'($urandom); ID_MemWrite = 1'($urandom);
  endtask

  task automatic no_fwd();
    MEM_RegWrite = 1'b0; MEM_Rd = '0; MEM_Data = '0;
    WB_RegWrite = 1'b0; WB_Rd = '0; WB_Data = '0;
  endtask

  task automatic set_plain(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic [31:0] rsd, input logic [31:0] rtd);
    rand_id();
    ID_Rs = rs; ID_Rt = rt; ID_Rd = rd; ID_RsData = rsd; ID_RtData = rtd;
    ID_ALUSrc = 1'b0; ID_RegWrite = 1'b1; ID_MemRead = 1'b0; ID_MemWrite = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; Flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rand_id();
      tick();
    end
    rand_id();
    no_fwd();
    #1;
    tests++;
    if (dut_out !== '0) begin
      fails++; $display("FAIL reset_out: got %h want 0", dut_out);
    end
    tests++;
    if (Stall !== 1'b0) begin
      fails++; $display("FAIL reset_stall: got %b want 0", Stall);
    end
    rst = 1'b0;
    set_plain(5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
    tick();
    ID_Valid = 1'b0;
    #1;
    tests++;
    if (EX_DataA !== 32'd5 || EX_DataB !== 32'd7 || EX_RegWrite !== 1'b1 || EX_Valid !== 1'b1) begin
      fails++;
      $display("FAIL first_add: got A=%h B=%h rw=%b v=%b want A=5 B=7 rw=1 v=1",
               EX_DataA, EX_DataB, EX_RegWrite, EX_Valid);
    end
    tests++;
    if (dut_out !== exp_out()) begin
      fails++; $display("FAIL first_add_all: got %h want %h", dut_out, exp_out());
    end
  endtask

  task automatic test_forward();
    set_plain(5'd4, 5'd4, 5'd9, 32'd1, 32'd1);
    tick();
    ID_Valid = 1'b0;
    MEM_RegWrite = 1'b1; MEM_Rd = 5'd4; MEM_Data = 32'h10;
    WB_RegWrite = 1'b1; WB_Rd = 5'd4; WB_Data = 32'h20;
    #1;
    tests++;
    if (EX_DataA !== 32'h10 || EX_DataB !== 32'h10) begin
      fails++; $display("FAIL fwd_mem_prio: got A=%h B=%h want 10 10", EX_DataA, EX_DataB);
    end
    MEM_RegWrite = 1'b0;
    #1;
    tests++;
    if (EX_DataA !== 32'h20 || EX_DataB !== 32'h20) begin
      fails++; $display("FAIL fwd_wb: got A=%h B=%h want 20 20", EX_DataA, EX_DataB);
    end
    MEM_RegWrite = 1'b1; MEM_Rd = '0; WB_Rd = '0;
    #1;
    tests++;
    if (EX_DataA !== 32'h1 || EX_DataB !== 32'h1) begin
      fails++; $display("FAIL fwd_r0: got A=%h B=%h want 1 1", EX_DataA, EX_DataB);
    end
    no_fwd();
  endtask

  task automatic test_immediate();
    set_plain(5'd2, 5'd6, 5'd9, 32'h3, 32'h4);
    ID_ALUSrc = 1'b1; ID_Imm = 32'hFFFF_FFFC;
    tick();
    ID_Valid = 1'b0;
    MEM_RegWrite = 1'b1; MEM_Rd = 5'd6; MEM_Data = 32'h55;
    #1;
    tests++;
    if (EX_DataB !== 32'hFFFF_FFFC || EX_StoreData !== 32'h55) begin
      fails++; $display("FAIL imm: got B=%h SD=%h want fffffffc 55", EX_DataB, EX_StoreData);
    end
    no_fwd();
  endtask

  task automatic load_to_ex(input logic [4:0] rd);
    set_plain(5'd1, 5'd2, rd, 32'h0, 32'h0);
    ID_MemRead = 1'b1;
    tick();
  endtask

  task automatic test_load_use();
    load_to_ex(5'd5);
    set_plain(5'd5, 5'd3, 5'd8, 32'hAA, 32'hBB);
    #1;
    tests++;
    if (Stall !== 1'b1) begin
      fails++; $display("FAIL lu_stall: got %b want 1", Stall);
    end
    tick();
    tests++;
    if (Stall !== 1'b0 || EX_Valid !== 1'b0 || EX_MemRead !== 1'b0) begin
      fails++;
      $display("FAIL lu_bubble: got stall=%b v=%b mr=%b want 0 0 0", Stall, EX_Valid, EX_MemRead);
    end
    tick();
    ID_Valid = 1'b0;
    #1;
    tests++;
    if (EX_Valid !== 1'b1 || EX_DataA !== 32'hAA || dut_out !== exp_out()) begin
      fails++; $display("FAIL lu_dep_load: got %h want %h", dut_out, exp_out());
    end
    load_to_ex(5'd0);
    set_plain(5'd0, 5'd0, 5'd8, 32'h1, 32'h2);
    #1;
    tests++;
    if (Stall !== 1'b0) begin
      fails++; $display("FAIL lu_r0: got %b want 0", Stall);
    end
    tick();
  endtask

  task automatic test_flush();
    load_to_ex(5'd5);
    set_plain(5'd5, 5'd5, 5'd8, 32'h1, 32'h2);
    ID_MemWrite = 1'b1;
    Flush = 1'b1;
    #1;
    tests++;
    if (Stall !== 1'b0) begin
      fails++; $display("FAIL flush_stall: got %b want 0", Stall);
    end
    tick();
    Flush = 1'b0;
    ID_Valid = 1'b0;
    #1;
    tests++;
    if (EX_Valid !== 1'b0 || EX_RegWrite !== 1'b0 || EX_MemWrite !== 1'b0) begin
      fails++;
      $display("FAIL flush_bubble: got v=%b rw=%b mw=%b want 0 0 0", EX_Valid, EX_RegWrite, EX_MemWrite);
    end
  endtask

  task automatic test_reset_stall();
    load_to_ex(5'd7);
    set_plain(5'd7, 5'd1, 5'd8, 32'h1, 32'h2);
    #1;
    tests++;
    if (Stall !== 1'b1) begin
      fails++; $display("FAIL rs_stall_pre: got %b want 1", Stall);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    tests++;
    if (dut_out !== '0 || Stall !== 1'b0) begin
      fails++; $display("FAIL rs_stall_clear: got out=%h stall=%b want 0 0", dut_out, Stall);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rand_id();
      ID_Valid = ($urandom_range(0, 7) != 0);
      Flush = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 31) == 0);
      MEM_RegWrite = 1'($urandom); MEM_Rd = 5'($urandom_range(0, 7)); MEM_Data = $urandom;
      WB_RegWrite = 1'($urandom); WB_Rd = 5'($urandom_range(0, 7)); WB_Data = $urandom;
      #1;
      tests++;
      if (Stall !== exp_stall()) begin
        fails++; $display("FAIL rand_stall[%0d]: got %b want %b", i, Stall, exp_stall());
      end
      tests++;
      if (dut_out !== exp_out()) begin
        fails++; $display("FAIL rand_out[%0d]: got %h want %h", i, dut_out, exp_out());
      end
      tick();
    end
    rst = 1'b0; Flush = 1'b0;
    no_fwd();
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_forward();
    test_immediate();
    test_load_use();
    test_flush();
    test_reset_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
